gf180mcu_osu_sc_gp9t3v3__inv_pipe: RTL

//  Parametrised, pipelined, polarity-programmable inverter bank: WIDTH-bit words enter on a valid/ready

---
 rtl/gf180mcu_osu_sc_gp9t3v3__inv_pipe.sv | 79 +++++++
 1 files changed

// File: rtl/gf180mcu_osu_sc_gp9t3v3__inv_pipe.sv
// Pipelined, polarity-programmable inverter bank with valid/ready backpressure.
// Words are XORed with the polarity mask on entry and leave DEPTH stages later.
module gf180mcu_osu_sc_gp9t3v3__inv_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] POL_RESET = '1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         pol_wr,
    input  logic [WIDTH-1:0]             pol_data,
    output logic [WIDTH-1:0]             pol,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];
    logic             accept;

    // Ready chain resolved from the output end backwards; a running term keeps
    // each bit a function of registers and out_ready only.
    always_comb begin
        logic run;
        adv = '0;
        run = vld[DEPTH-1] & out_ready;
        adv[DEPTH-1] = run;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            run = vld[DEPTH-2-i] & (~vld[DEPTH-1-i] | run);
            adv[DEPTH-2-i] = run;
        end
    end

    assign in_ready  = ~vld[0] | adv[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = data[DEPTH-1];

    always_comb begin
        int unsigned cnt;
        cnt = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            cnt += 32'(vld[k]);
        end
        occupancy = ($clog2(DEPTH+1))'(cnt);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld <= '0;
            pol <= POL_RESET;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (pol_wr) begin
                pol <= pol_data;
            end
            // Entry uses the mask as it stood before any same-cycle pol_wr.
            if (accept) begin
                data[0] <= in_data ^ pol;
            end
            vld[0] <= accept | (vld[0] & ~adv[0]);
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    data[k] <= data[k-1];
                end
                vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
            end
        end
    end

endmodule
